// File: rtl/wormy_pkg.sv
// wormy_pkg: direction codes shared by the wormy game core and its input
// controller, the opposite-direction helper, and the default debounce length.
//   dir_t                   : 2-bit direction code (0 up, 1 right, 2 down, 3 left)
//   opposite()              : returns the reverse heading of a direction
//   DEBOUNCE_CYCLES_DEFAULT : default number of cycles a button must hold a new level
package wormy_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;

  // Opposite headings differ only in the upper code bit.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/wormy_debounce.sv
// wormy_debounce: two-flop synchronizer followed by a saturating-run debounce
// counter for one push button.
//   clk, rst : clock, synchronous active-high reset
//   btn_raw  : asynchronous raw button level
//   stable   : debounced button level
//   rise     : one-cycle pulse in the first cycle stable reads 1 after a 0->1 flip
module wormy_debounce
  import wormy_pkg::*;
#(
  parameter int unsigned DebounceCycles = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic stable,
  output logic rise
);

  localparam logic [15:0] CntMax = 16'(DebounceCycles - 1);

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        stable_q, stable_d;
  logic        rise_q, rise_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      // Any return to the stable level restarts the run.
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      stable_d = sync2_q;
      rise_d   = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;

endmodule

// File: rtl/wormy_input_ctrl.sv
// wormy_input_ctrl: debounces the four direction buttons, picks one press per
// cycle, rejects repeats/reversals, queues accepted turns and hands at most one
// turn per game tick to the core.
//   clk, rst      : clock, synchronous active-high reset
//   btn_raw[3:0]  : raw buttons, bit i requests direction code i
//   tick          : one-cycle pulse coincident with the core's update pulse
//   button_pushed : registered one-cycle turn strobe
//   button_state  : registered direction code, valid with button_pushed
//   queue_full    : registered, queue holds QueueDepth entries
//   drop          : registered one-cycle pulse, a press event was discarded
module wormy_input_ctrl
  import wormy_pkg::*;
#(
  parameter int unsigned DebounceCycles = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned QueueDepth     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  input  logic       tick,
  output logic       button_pushed,
  output logic [1:0] button_state,
  output logic       queue_full,
  output logic       drop
);

  localparam int unsigned PtrW = $clog2(QueueDepth);
  localparam int unsigned OccW = PtrW + 1;
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [OccW-1:0] OccOne  = OccW'(1);
  localparam logic [OccW-1:0] OccFull = OccW'(QueueDepth);

  // ---------------- debounce, one instance per button ----------------
  logic [3:0] stable_vec;
  logic [3:0] rise_vec;
  logic [3:0] press_evt;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      wormy_debounce #(
        .DebounceCycles(DebounceCycles)
      ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw[gi]),
        .stable  (stable_vec[gi]),
        .rise    (rise_vec[gi])
      );
    end
  endgenerate

  // rise already implies stable; the AND just keeps the event tied to the
  // level it reports.
  assign press_evt = rise_vec & stable_vec;

  // ---------------- arbitration: lowest index wins ----------------
  logic evt_any;
  logic evt_multi;
  dir_t evt_dir;

  always_comb begin
    evt_any   = |press_evt;
    evt_multi = (press_evt & (press_evt - 4'd1)) != 4'd0;
    evt_dir   = DIR_UP;
    for (int i = 3; i >= 0; i--) begin
      if (press_evt[i]) evt_dir = dir_t'(2'(i));
    end
  end

  // ---------------- queue, filter and issue gating ----------------
  dir_t            fifo_q [QueueDepth];
  dir_t            fifo_d [QueueDepth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0] occ_q, occ_d;
  dir_t            committed_q, committed_d;
  logic            armed_q, armed_d;
  logic            button_pushed_q, button_pushed_d;
  dir_t            button_state_q, button_state_d;
  logic            queue_full_q, queue_full_d;
  logic            drop_q, drop_d;

  logic            q_empty;
  logic            q_full_now;
  logic [PtrW-1:0] newest_ptr;
  dir_t            head_dir;
  dir_t            ref_dir;
  logic            issue;
  logic            accept;

  always_comb begin
    q_empty    = (occ_q == '0);
    q_full_now = (occ_q == OccFull);
    newest_ptr = wr_ptr_q - PtrOne;
    head_dir   = fifo_q[rd_ptr_q];
    // Filter against the pre-pop newest entry so a turn is judged against the
    // heading it will follow, not against what is being issued this cycle.
    ref_dir    = q_empty ? committed_q : fifo_q[newest_ptr];
    // The core ignores strobes in its update cycle, so never issue on tick.
    issue      = armed_q && !q_empty && !tick;
    // A full queue still accepts when a pop frees a slot in the same cycle.
    accept     = evt_any && (evt_dir != ref_dir) && (evt_dir != opposite(ref_dir))
                 && (!q_full_now || issue);

    fifo_d = fifo_q;
    if (accept) fifo_d[wr_ptr_q] = evt_dir;
    wr_ptr_d = accept ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = issue  ? rd_ptr_q + PtrOne : rd_ptr_q;

    unique case ({accept, issue})
      2'b10:   occ_d = occ_q + OccOne;
      2'b01:   occ_d = occ_q - OccOne;
      default: occ_d = occ_q;
    endcase

    committed_d = issue ? head_dir : committed_q;
    // Re-arm on each tick; an issue consumes the arm so only one turn goes
    // out per tick interval.
    if (issue)     armed_d = 1'b0;
    else if (tick) armed_d = 1'b1;
    else           armed_d = armed_q;

    button_pushed_d = issue;
    button_state_d  = issue ? head_dir : DIR_UP;
    queue_full_d    = (occ_d == OccFull);
    drop_d          = evt_multi || (evt_any && !accept);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(QueueDepth); i++) fifo_q[i] <= DIR_UP;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      occ_q           <= '0;
      committed_q     <= DIR_UP;
      armed_q         <= 1'b1;
      button_pushed_q <= 1'b0;
      button_state_q  <= DIR_UP;
      queue_full_q    <= 1'b0;
      drop_q          <= 1'b0;
    end else begin
      fifo_q          <= fifo_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      occ_q           <= occ_d;
      committed_q     <= committed_d;
      armed_q         <= armed_d;
      button_pushed_q <= button_pushed_d;
      button_state_q  <= button_state_d;
      queue_full_q    <= queue_full_d;
      drop_q          <= drop_d;
    end
  end

  assign button_pushed = button_pushed_q;
  assign button_state  = button_state_q;
  assign queue_full    = queue_full_q;
  assign drop          = drop_q;

endmodule

// File: tb/tb_wormy_input_ctrl.sv
// Directed bench for wormy_input_ctrl with DebounceCycles=4, QueueDepth=2.
// Buttons are driven on the falling edge; with a press applied there, the
// debounced flip lands on the 6th rising edge, the push on the 7th and the
// earliest strobe is visible after the 8th.
module tb_wormy_input_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_raw;
  logic       tick;
  logic       button_pushed;
  logic [1:0] button_state;
  logic       queue_full;
  logic       drop;

  int vectors     = 0;
  int miscompares = 0;
  int strobe_cnt  = 0;
  int drop_cnt    = 0;
  int s0;
  int d0;

  always #5 clk = ~clk;

  wormy_input_ctrl #(
    .DebounceCycles (4),
    .QueueDepth     (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_raw       (btn_raw),
    .tick          (tick),
    .button_pushed (button_pushed),
    .button_state  (button_state),
    .queue_full    (queue_full),
    .drop          (drop)
  );

  // Pulse counters: each rising edge tallies the values held in the cycle before it.
  always @(posedge clk) begin
    if (button_pushed === 1'b1) strobe_cnt++;
    if (drop === 1'b1) drop_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic release_btns();
    btn_raw = 4'b0000;
    cyc(10);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  initial begin
    rst = 1'b1; btn_raw = 4'b0000; tick = 1'b0;
    cyc(3);
    chk("reset_pushed", 8'(button_pushed), 8'h0);
    chk("reset_state",  8'(button_state),  8'h0);
    chk("reset_full",   8'(queue_full),    8'h0);
    chk("reset_drop",   8'(drop),          8'h0);
    rst = 1'b0;
    cyc(2);

    // Single turn: right, armed from reset, issued with no tick.
    btn_raw = 4'b0010;
    cyc(7);
    chk("single_no_strobe_e7", 8'(button_pushed), 8'h0);
    chk("single_no_drop_e7",   8'(drop),          8'h0);
    cyc(1);
    chk("single_strobe_e8",    8'(button_pushed), 8'h1);
    chk("single_state_e8",     8'(button_state),  8'h1);
    cyc(1);
    chk("single_strobe_e9",    8'(button_pushed), 8'h0);
    release_btns();

    // committed=right, armed=0. Left is a reversal, right a repeat.
    btn_raw = 4'b1000;
    cyc(7);
    chk("reversal_drop",       8'(drop), 8'h1);
    cyc(1);
    chk("reversal_drop_once",  8'(drop), 8'h0);
    release_btns();
    btn_raw = 4'b0010;
    cyc(7);
    chk("repeat_drop",         8'(drop), 8'h1);
    release_btns();
    // Down is legal and waits for a tick.
    btn_raw = 4'b0100;
    cyc(7);
    chk("down_accept_nodrop",  8'(drop),       8'h0);
    chk("down_accept_notfull", 8'(queue_full), 8'h0);
    s0 = strobe_cnt;
    release_btns();
    chk("down_waits_for_tick", 8'(strobe_cnt - s0), 8'h0);
    tick = 1'b1;
    cyc(1);
    chk("down_no_strobe_on_tick", 8'(button_pushed), 8'h0);
    tick = 1'b0;
    cyc(1);
    chk("down_strobe",         8'(button_pushed), 8'h1);
    chk("down_state",          8'(button_state),  8'h2);
    cyc(5);

    // Tick with an empty queue: arms but nothing to issue.
    s0 = strobe_cnt;
    pulse_tick();
    cyc(10);
    chk("empty_tick_no_strobe", 8'(strobe_cnt - s0), 8'h0);

    // Glitch: 3-cycle pulse on left while armed.
    s0 = strobe_cnt; d0 = drop_cnt;
    btn_raw = 4'b1000;
    cyc(3);
    btn_raw = 4'b0000;
    cyc(12);
    chk("glitch_no_strobe", 8'(strobe_cnt - s0), 8'h0);
    chk("glitch_no_drop",   8'(drop_cnt - d0),   8'h0);
    chk("glitch_not_full",  8'(queue_full),      8'h0);

    // Armed and committed=down: right goes straight out.
    btn_raw = 4'b0010;
    cyc(8);
    chk("armed_right_strobe", 8'(button_pushed), 8'h1);
    chk("armed_right_state",  8'(button_state),  8'h1);
    release_btns();

    // Queue fill: committed=right, armed=0.
    s0 = strobe_cnt;
    btn_raw = 4'b0100;
    cyc(7);
    chk("q_down_notfull", 8'(queue_full), 8'h0);
    chk("q_down_nodrop",  8'(drop),       8'h0);
    release_btns();
    btn_raw = 4'b1000;
    cyc(7);
    chk("q_left_full",    8'(queue_full), 8'h1);
    chk("q_left_nodrop",  8'(drop),       8'h0);
    release_btns();
    btn_raw = 4'b0010;
    cyc(7);
    chk("q_right_drop",   8'(drop),       8'h1);
    release_btns();
    // Up is neither repeat nor reversal of left, so only fullness drops it.
    btn_raw = 4'b0001;
    cyc(7);
    chk("q_up_full_drop", 8'(drop),       8'h1);
    chk("q_still_full",   8'(queue_full), 8'h1);
    release_btns();
    chk("q_no_strobe_unarmed", 8'(strobe_cnt - s0), 8'h0);

    // Rate limit: one strobe per 300-cycle tick interval, in order.
    pulse_tick();
    cyc(1);
    chk("rate_first_strobe", 8'(button_pushed), 8'h1);
    chk("rate_first_state",  8'(button_state),  8'h2);
    chk("rate_first_notfull", 8'(queue_full),   8'h0);
    cyc(297);
    chk("rate_one_per_interval", 8'(strobe_cnt - s0), 8'h1);
    pulse_tick();
    cyc(1);
    chk("rate_second_strobe", 8'(button_pushed), 8'h1);
    chk("rate_second_state",  8'(button_state),  8'h3);
    cyc(298);
    chk("rate_two_total", 8'(strobe_cnt - s0), 8'h2);

    // Tick collision: committed=left; arm first, then tick on the issue cycle.
    pulse_tick();
    cyc(5);
    btn_raw = 4'b0100;
    cyc(7);
    tick = 1'b1;
    cyc(1);
    chk("collide_no_strobe", 8'(button_pushed), 8'h0);
    tick = 1'b0;
    cyc(1);
    chk("collide_strobe_next", 8'(button_pushed), 8'h1);
    chk("collide_state",       8'(button_state),  8'h2);
    release_btns();

    // Simultaneous right+left, committed=down: right wins, one drop.
    d0 = drop_cnt;
    btn_raw = 4'b1010;
    cyc(7);
    chk("simul_drop",    8'(drop),       8'h1);
    chk("simul_notfull", 8'(queue_full), 8'h0);
    release_btns();
    chk("simul_one_drop", 8'(drop_cnt - d0), 8'h1);
    pulse_tick();
    cyc(1);
    chk("simul_strobe", 8'(button_pushed), 8'h1);
    chk("simul_state",  8'(button_state),  8'h1);
    cyc(3);

    // Reset with two entries queued (committed=right, armed=0).
    btn_raw = 4'b0100;
    cyc(7);
    release_btns();
    btn_raw = 4'b1000;
    cyc(7);
    chk("prereset_full", 8'(queue_full), 8'h1);
    release_btns();
    rst = 1'b1;
    cyc(1);
    chk("rst_pushed", 8'(button_pushed), 8'h0);
    chk("rst_state",  8'(button_state),  8'h0);
    chk("rst_full",   8'(queue_full),    8'h0);
    chk("rst_drop",   8'(drop),          8'h0);
    rst = 1'b0;
    s0 = strobe_cnt;
    pulse_tick();
    cyc(5);
    chk("rst_flushed_no_strobe", 8'(strobe_cnt - s0), 8'h0);
    // committed back to up: up repeats, down reverses.
    btn_raw = 4'b0001;
    cyc(7);
    chk("rst_up_repeat_drop", 8'(drop), 8'h1);
    release_btns();
    btn_raw = 4'b0100;
    cyc(7);
    chk("rst_down_reversal_drop", 8'(drop), 8'h1);
    release_btns();

    // Button held through reset yields one fresh press afterwards.
    btn_raw = 4'b0010;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(7);
    chk("held_no_strobe_e7", 8'(button_pushed), 8'h0);
    cyc(1);
    chk("held_strobe_e8", 8'(button_pushed), 8'h1);
    chk("held_state_e8",  8'(button_state),  8'h1);
    release_btns();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
